// File: rtl/vga_sync_timing.sv
// 640x480@60 VGA timing generator with a single aligned output register stage.
// Upstream drawing logic reads px/py and returns colour combinationally in the
// same clock. Colour, sync and blank are registered together, so all DAC-side
// outputs lag px/py by exactly one clock.
module vga_sync_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNCW   = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNCW   = 2,
    parameter int V_BACK    = 33
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [9:0] iRed,
    input  logic [9:0] iGreen,
    input  logic [9:0] iBlue,
    output logic [9:0] px,
    output logic [9:0] py,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B,
    output logic       VGA_H_SYNC,
    output logic       VGA_V_SYNC,
    output logic       VGA_BLANK,
    output logic       VGA_SYNC
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNCW + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNCW + V_BACK;

    // 10-bit copies of the boundaries so every compare is unsigned 10-bit
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] H_SS   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SE   = 10'(H_VISIBLE + H_FRONT + H_SYNCW);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] V_SS   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SE   = 10'(V_VISIBLE + V_FRONT + V_SYNCW);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_vis;
    logic       v_vis;
    logic       visible;
    logic       hs_n;
    logic       vs_n;

    // Raster counters: h wraps each line, v steps on the last clock of a line
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Decode visible region, sync windows and published coordinates
    always_comb begin
        h_vis   = (h_cnt < H_VIS);
        v_vis   = (v_cnt < V_VIS);
        visible = h_vis && v_vis;
        hs_n    = !((h_cnt >= H_SS) && (h_cnt < H_SE));
        vs_n    = !((v_cnt >= V_SS) && (v_cnt < V_SE));
        px      = h_vis ? h_cnt : 10'd0;
        py      = v_vis ? v_cnt : 10'd0;
    end

    // Output stage: colour gated by visibility, registered alongside sync/blank
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            VGA_R      <= '0;
            VGA_G      <= '0;
            VGA_B      <= '0;
            VGA_H_SYNC <= 1'b1;
            VGA_V_SYNC <= 1'b1;
            VGA_BLANK  <= 1'b0;
        end else begin
            VGA_R      <= visible ? iRed   : 10'd0;
            VGA_G      <= visible ? iGreen : 10'd0;
            VGA_B      <= visible ? iBlue  : 10'd0;
            VGA_H_SYNC <= hs_n;
            VGA_V_SYNC <= vs_n;
            VGA_BLANK  <= visible;
        end
    end

    // No sync-on-green
    assign VGA_SYNC = 1'b0;

endmodule

// File: tb/tb_vga_sync_timing.sv
// Bench for vga_sync_timing. Horizontal geometry is the full 800-clock line;
// vertical is shrunk (13 visible, 1 front, 2 sync, 1 back = 17 lines,
// VS on lines 14..15) so whole frames fit in a short run.
module tb_vga_sync_timing;

    localparam int HT = 800;
    localparam int VT = 17;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic [9:0] iRed, iGreen, iBlue;
    logic [9:0] px, py, VGA_R, VGA_G, VGA_B;
    logic       VGA_H_SYNC, VGA_V_SYNC, VGA_BLANK, VGA_SYNC;

    int n_chk  = 0;
    int n_fail = 0;
    int h_m    = 0;   // raster position the DUT should be at
    int v_m    = 0;

    vga_sync_timing #(
        .V_VISIBLE(13), .V_FRONT(1), .V_SYNCW(2), .V_BACK(1)
    ) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .px(px), .py(py),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_H_SYNC(VGA_H_SYNC), .VGA_V_SYNC(VGA_V_SYNC),
        .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC)
    );

    always #5 iCLK = ~iCLK;

    // Drawing logic stand-in: colour follows the published coordinate
    always_comb begin
        iRed   = px;
        iGreen = py;
        iBlue  = 10'h3FF;
    end

    typedef struct {
        int         h, v;
        logic [9:0] px, py, r, g, b;
        logic       bl, hs, vs;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One clock; outputs are sampled on the following negedge
    task automatic step();
        @(posedge iCLK);
        if (iRST) begin
            h_m = 0;
            v_m = 0;
        end else if (h_m == HT - 1) begin
            h_m = 0;
            v_m = (v_m == VT - 1) ? 0 : v_m + 1;
        end else begin
            h_m = h_m + 1;
        end
        @(negedge iCLK);
    endtask

    task automatic nav(input int h, input int v);
        int n = 0;
        while (!(h_m == h && v_m == v) && n < 20000) begin
            step();
            n++;
        end
        chk($sformatf("nav(%0d,%0d) reached", h, v), (n < 20000), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_blr, t_blf, t_hf0, t_hf1, t_hr, t_vf, t_vr, t_vf2;
        int bl_cnt, py_max, py_bad;
        logic p_hs, p_bl, p_vs;

        //            h    v    px   py   r    g    b        bl hs vs
        tbl[0]  = '{ 37,  0,  37,   0,  37,   0, 10'h3FF, 1, 1, 1};
        tbl[1]  = '{639,  0, 639,   0, 639,   0, 10'h3FF, 1, 1, 1};
        tbl[2]  = '{640,  0,   0,   0,   0,   0, 10'h000, 0, 1, 1};
        tbl[3]  = '{655,  0,   0,   0,   0,   0, 10'h000, 0, 1, 1};
        tbl[4]  = '{656,  0,   0,   0,   0,   0, 10'h000, 0, 0, 1};
        tbl[5]  = '{700,  0,   0,   0,   0,   0, 10'h000, 0, 0, 1};
        tbl[6]  = '{751,  0,   0,   0,   0,   0, 10'h000, 0, 0, 1};
        tbl[7]  = '{752,  0,   0,   0,   0,   0, 10'h000, 0, 1, 1};
        tbl[8]  = '{799,  0,   0,   0,   0,   0, 10'h000, 0, 1, 1};
        tbl[9]  = '{  0,  1,   0,   1,   0,   1, 10'h3FF, 1, 1, 1};
        tbl[10] = '{ 37, 12,  37,  12,  37,  12, 10'h3FF, 1, 1, 1};
        tbl[11] = '{639, 12, 639,  12, 639,  12, 10'h3FF, 1, 1, 1};
        tbl[12] = '{100, 13, 100,   0,   0,   0, 10'h000, 0, 1, 1};
        tbl[13] = '{  5, 14,   5,   0,   0,   0, 10'h000, 0, 1, 0};
        tbl[14] = '{799, 15,   0,   0,   0,   0, 10'h000, 0, 1, 0};
        tbl[15] = '{  0, 16,   0,   0,   0,   0, 10'h000, 0, 1, 1};
        tbl[16] = '{799, 16,   0,   0,   0,   0, 10'h000, 0, 1, 1};
        tbl[17] = '{  0,  0,   0,   0,   0,   0, 10'h3FF, 1, 1, 1};

        // Reset held for 5 clocks
        iRST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst hs", VGA_H_SYNC, 1);
            chk("rst vs", VGA_V_SYNC, 1);
            chk("rst blank", VGA_BLANK, 0);
            chk("rst rgb", {VGA_R, VGA_G, VGA_B}, 0);
            chk("rst px/py", {px, py}, 0);
            chk("rst sync", VGA_SYNC, 0);
        end
        iRST = 1'b0;
        chk("post-rst px", px, 0);
        chk("post-rst py", py, 0);
        step();
        chk("post-rst blank", VGA_BLANK, 1);
        chk("post-rst b", VGA_B, 10'h3FF);

        // Positional vectors through one frame and into the next
        for (int i = 0; i < 18; i++) begin
            nav(tbl[i].h, tbl[i].v);
            chk($sformatf("v%0d px", i), px, tbl[i].px);
            chk($sformatf("v%0d py", i), py, tbl[i].py);
            step();
            chk($sformatf("v%0d r", i), VGA_R, tbl[i].r);
            chk($sformatf("v%0d g", i), VGA_G, tbl[i].g);
            chk($sformatf("v%0d b", i), VGA_B, tbl[i].b);
            chk($sformatf("v%0d blank", i), VGA_BLANK, tbl[i].bl);
            chk($sformatf("v%0d hs", i), VGA_H_SYNC, tbl[i].hs);
            chk($sformatf("v%0d vs", i), VGA_V_SYNC, tbl[i].vs);
        end

        // Line timing measured from output edges
        nav(0, 2);
        t_blr = -1; t_blf = -1; t_hf0 = -1; t_hf1 = -1; t_hr = -1;
        p_hs = VGA_H_SYNC;
        p_bl = VGA_BLANK;
        for (int c = 0; c < 1700; c++) begin
            step();
            if (!p_bl && VGA_BLANK && t_blr < 0) t_blr = c;
            if (p_bl && !VGA_BLANK && t_blf < 0) t_blf = c;
            if (p_hs && !VGA_H_SYNC) begin
                if (t_hf0 < 0) t_hf0 = c;
                else if (t_hf1 < 0) t_hf1 = c;
            end
            if (!p_hs && VGA_H_SYNC && t_hr < 0 && t_hf0 >= 0) t_hr = c;
            p_hs = VGA_H_SYNC;
            p_bl = VGA_BLANK;
        end
        chk("blank high len", t_blf - t_blr, 640);
        chk("hs low len", t_hr - t_hf0, 96);
        chk("hs period", t_hf1 - t_hf0, 800);
        chk("hs fall after line start", t_hf0 - t_blr, 656);

        // Mid-frame reset for one clock
        nav(300, 10);
        iRST = 1'b1;
        step();
        iRST = 1'b0;
        chk("mrst hs", VGA_H_SYNC, 1);
        chk("mrst vs", VGA_V_SYNC, 1);
        chk("mrst blank", VGA_BLANK, 0);
        chk("mrst rgb", {VGA_R, VGA_G, VGA_B}, 0);
        chk("mrst px", px, 0);
        chk("mrst py", py, 0);
        chk("mrst sync", VGA_SYNC, 0);
        t_hf0 = -1; t_vf = -1;
        p_hs = VGA_H_SYNC;
        p_vs = VGA_V_SYNC;
        for (int c = 0; c < 12000 && t_vf < 0; c++) begin
            step();
            if (c == 0) chk("mrst first blank", VGA_BLANK, 1);
            if (p_hs && !VGA_H_SYNC && t_hf0 < 0) t_hf0 = c;
            if (p_vs && !VGA_V_SYNC) t_vf = c;
            p_hs = VGA_H_SYNC;
            p_vs = VGA_V_SYNC;
        end
        chk("mrst hs restart", t_hf0, 656);
        chk("mrst vs restart", t_vf, 14 * 800);

        // Frame timing from the VS fall just seen
        p_vs = 1'b0;
        t_vr = -1; t_vf2 = -1; bl_cnt = 0; py_max = 0; py_bad = 0;
        for (int c = 1; c <= 13600; c++) begin
            step();
            if (!p_vs && VGA_V_SYNC && t_vr < 0) t_vr = c;
            if (p_vs && !VGA_V_SYNC && t_vf2 < 0) t_vf2 = c;
            if (VGA_BLANK) bl_cnt++;
            if (int'(py) > py_max) py_max = int'(py);
            if (v_m >= 13 && py != 0) py_bad++;
            p_vs = VGA_V_SYNC;
        end
        chk("vs low len", t_vr, 1600);
        chk("vs period", t_vf2, 13600);
        chk("blank clocks per frame", bl_cnt, 13 * 640);
        chk("py max", py_max, 12);
        chk("py nonzero in vblank", py_bad, 0);
        chk("sync tied low", VGA_SYNC, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_timing.md
Name: vga_sync_timing

Overview:
- 640x480 at 60 Hz VGA timing generator and pixel output stage.
- Runs on the pixel clock: 25.175 MHz nominal, 25 MHz acceptable.
- Publishes the current visible pixel coordinate to upstream drawing logic.
- Takes back that logic's combinational colour, then drives the DAC colour, sync and blank lines with all outputs aligned.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch in clocks
- H_SYNCW, 96, horizontal sync pulse width in clocks
- H_BACK, 48, horizontal back porch in clocks
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNCW, 2, vertical sync pulse width in lines
- V_BACK, 33, vertical back porch in lines

Ports:
- iCLK  in  1  pixel clock; all logic rises on posedge
- iRST  in  1  synchronous reset, active-high
- iRed  in  10  red for the pixel at current px/py
- iGreen  in  10  green for the pixel at current px/py
- iBlue  in  10  blue for the pixel at current px/py
- px  out  10  current visible column, 0..639
- py  out  10  current visible row, 0..479
- VGA_R  out  10  red to DAC
- VGA_G  out  10  green to DAC
- VGA_B  out  10  blue to DAC
- VGA_H_SYNC  out  1  horizontal sync, active-low
- VGA_V_SYNC  out  1  vertical sync, active-low
- VGA_BLANK  out  1  blank, active-low: 1 means visible
- VGA_SYNC  out  1  composite sync-on-green, tied to 0

Behaviour:
- Counters:
  - h_cnt is 10 bits and counts 0..H_TOTAL-1, where H_TOTAL = 800; it wraps to 0.
  - v_cnt is 10 bits and increments only when h_cnt == H_TOTAL-1; it wraps to 0 after V_TOTAL-1, where V_TOTAL = 525.
- Visible region: visible = (h_cnt < H_VISIBLE) and (v_cnt < V_VISIBLE). Count 0 is the first visible pixel/line.
- Coordinates, combinational from the counters:
  - px = h_cnt when h_cnt < H_VISIBLE, else 0.
  - py = v_cnt when v_cnt < V_VISIBLE, else 0.
- Horizontal sync: hs_n = 0 when H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNCW, i.e. 656..751; otherwise 1.
- Vertical sync: vs_n = 0 when V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNCW, i.e. lines 490..491, for the whole of each of those lines; otherwise 1.
- Output register stage:
  - On every posedge: VGA_R/G/B <= visible ? iRed/iGreen/iBlue : 0.
  - VGA_H_SYNC <= hs_n, VGA_V_SYNC <= vs_n, VGA_BLANK <= visible.
  - Latency is exactly 1 clock from px/py to the colour/sync/blank outputs for that pixel, so all DAC-side outputs stay mutually aligned.
- Colour gating: colour outside the visible region is forced to 0 regardless of the iRed/iGreen/iBlue inputs.
- Frame timing: 800 × 525 = 420000 clocks per frame; HS period is 800 clocks; VS period is 420000 clocks.
- Reset, while iRST = 1 at posedge:
  - h_cnt = v_cnt = 0.
  - VGA_R/G/B = 0, VGA_H_SYNC = 1, VGA_V_SYNC = 1, VGA_BLANK = 0.
  - px = py = 0.
- After reset: the first clock after iRST falls produces pixel (0,0) on px/py; the outputs show it one clock later.
- Reset mid-frame: takes effect at the next posedge with no partial-line completion; timing restarts at (0,0).
- Widths: the counters never exceed 799/524. All comparisons are unsigned 10-bit.
- VGA_SYNC is constant 0 in all states, including reset.

Test Plan:
- Reset held 5 clocks, then released: during reset HS=VS=1, BLANK=0, RGB=0, px=py=0. The first post-reset clock gives px=0, py=0; the next clock gives BLANK=1.
- Line timing, free-running: HS low for exactly 96 clocks, with falling edges 800 clocks apart. HS falls 657 clocks after px=0, i.e. the registered image of h_cnt 656. BLANK high for exactly 640 consecutive clocks per visible line.
- Frame timing: VS low for exactly 1600 clocks (2 lines), with falling edges 420000 clocks apart. BLANK stays 0 for all of lines 480..524. py runs 0..479 then reads 0 during vertical blanking.
- Colour path: drive iRed={px}, iGreen={py}, iBlue=10'h3FF combinationally.
  - At the output cycle after px=37, py=12: VGA_R=37, VGA_G=12, VGA_B=3FF.
  - At h_cnt=700: RGB=0 despite iBlue=3FF.
- Wrap: at h_cnt=799, v_cnt=524, the next clock gives px=0, py=0, and the following output clock gives BLANK=1 (new frame).
- Mid-frame reset: assert iRST at h_cnt=300, v_cnt=200 for 1 clock. The next clock shows reset values; after release, px=0, py=0, and HS/VS timing restarts from that point. VGA_SYNC stays 0 throughout.
